// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine: COLS_PER_CYCLE columns per clock,
// column 3 first, valid/ready on both sides.
module inv_mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned CNT_W    = 3;

    // Only divisors of the column count give a whole number of cycles.
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [STATE_W-1:0]   work_q;
    logic [STATE_W-1:0]   work_mix;
    logic [1:0]           col_idx;
    logic                 last_grp;

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the inverse mixing matrix {0e,0b,0d,09} (circulant).
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] r [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            r[i]  = col[8*(3-i) +: 8];
            x2    = xtime(r[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ r[i];
            mb[i] = x8 ^ x2 ^ r[i];
            md[i] = x8 ^ x4 ^ r[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Transform the current column group in place; other columns pass through.
    always_comb begin
        work_mix = work_q;
        col_idx  = 2'd0;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx = 2'(CNT_W'(NUM_COLS - 1) - cnt_q - CNT_W'(k));
            work_mix[col_idx*COL_W +: COL_W] = inv_mix_col(work_q[col_idx*COL_W +: COL_W]);
        end
    end

    assign last_grp = (cnt_q + CNT_W'(COLS_PER_CYCLE)) == CNT_W'(NUM_COLS);

    // DONE accepts a new block in the same cycle it hands one off.
    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign out_state = work_q;

    // Control FSM, column counter and working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                        busy    <= 1'b1;
                    end
                end
                BUSY: begin
                    work_q <= work_mix;
                    cnt_q  <= cnt_q + CNT_W'(COLS_PER_CYCLE);
                    if (last_grp) begin
                        state_q   <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            work_q  <= in_state;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: one instance per legal COLS_PER_CYCLE,
// checked against a generic GF(2^8) matrix model.
module tb_inv_mix_columns_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and log one observation.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Shift-and-add GF(2^8) product, polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product on every column; coefs = first matrix row.
    function automatic logic [127:0] mat_mix(input logic [127:0] s, input logic [31:0] coefs);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coefs[8*(3 - ((j - r) & 3)) +: 8], s[c*32 + 24 - 8*j +: 8]);
                o[c*32 + 24 - 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return mat_mix(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] ref_fwd(input logic [127:0] s);
        return mat_mix(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block through DUT d with latency check and a single output transfer.
    task automatic run_block(input int d, input logic [127:0] x, input logic [127:0] exp,
                             input string tag);
        int lat;
        check({tag, "_in_ready"}, 128'(in_ready[d]), 128'(1));
        in_valid[d] = 1'b1;
        in_state[d] = x;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_state[d] = rand128();
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(4 >> d));
        check({tag, "_data"}, out_state[d], exp);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check({tag, "_drain"}, 128'(out_valid[d]), 128'(0));
    endtask

    initial begin : main
        logic [127:0] x, e, held;
        logic [127:0] q [3];
        int sent, got, cyc, last_cyc;
        bit hs_in, hs_out;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 3; d++)
            check($sformatf("rst_in_ready_low%0d", d), 128'(in_ready[d]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_in_ready%0d", d), 128'(in_ready[d]), 128'(1));
            check($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
            check($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'(0));
            check($sformatf("rst_out_state%0d", d), out_state[d], 128'(0));
        end

        // Known vectors, boundary patterns and random round trips on each width.
        for (int d = 0; d < 3; d++) begin
            run_block(d, 128'h8e4da1bc_9fdc589d_4d7ebdf8_01010101,
                         128'hdb135345_f20a225c_2d26314c_01010101, $sformatf("fips%0d", d));
            run_block(d, 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6,
                         128'hc6c6c6c6_d4d4d4d5_01010101_c6c6c6c6, $sformatf("fixed%0d", d));
            run_block(d, '0, '0, $sformatf("zero%0d", d));
            run_block(d, '1, '1, $sformatf("ones%0d", d));
            for (int i = 0; i < 1000; i++) begin
                x = rand128();
                run_block(d, ref_fwd(x), x, $sformatf("rt%0d_%0d", d, i));
            end
            for (int i = 0; i < 20; i++) begin
                x = rand128();
                run_block(d, x, ref_inv(x), $sformatf("rnd%0d_%0d", d, i));
            end
        end

        // Backpressure: output held stable, inputs refused.
        x = rand128();
        e = ref_inv(x);
        in_valid[0] = 1'b1;
        in_state[0] = x;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("bp_valid_rise", 128'(out_valid[0]), 128'(1));
        held = rand128();
        for (int i = 0; i < 7; i++) begin
            in_valid[0] = (i == 3);
            in_state[0] = held;
            check($sformatf("bp_valid_%0d", i), 128'(out_valid[0]), 128'(1));
            check($sformatf("bp_data_%0d", i), out_state[0], e);
            check($sformatf("bp_in_ready_%0d", i), 128'(in_ready[0]), 128'(0));
            @(posedge clk); #1;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp_after_valid", 128'(out_valid[0]), 128'(0));
        check("bp_after_busy", 128'(busy[0]), 128'(0));
        check("bp_after_in_ready", 128'(in_ready[0]), 128'(1));
        repeat (6) begin @(posedge clk); #1; end
        check("bp_no_ghost", 128'(out_valid[0] | busy[0]), 128'(0));

        // Back-to-back: three queued blocks, one output every five cycles.
        for (int i = 0; i < 3; i++) q[i] = rand128();
        sent = 0; got = 0; cyc = 0; last_cyc = 0;
        in_valid[0]  = 1'b1;
        in_state[0]  = q[0];
        out_ready[0] = 1'b1;
        while (got < 3 && cyc < 100) begin
            hs_in  = in_valid[0] && in_ready[0];
            hs_out = out_valid[0] && out_ready[0];
            if (sent > 0)
                check($sformatf("b2b_busy_c%0d", cyc), 128'(busy[0]), 128'(1));
            if (hs_out) begin
                check($sformatf("b2b_data%0d", got), out_state[0], ref_inv(q[got]));
                if (got > 0)
                    check($sformatf("b2b_gap%0d", got), 128'(cyc - last_cyc), 128'(5));
                last_cyc = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (hs_in) begin
                sent++;
                if (sent < 3) in_state[0] = q[sent];
                else          in_valid[0] = 1'b0;
            end
        end
        check("b2b_count", 128'(got), 128'(3));
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 128'(busy[0]), 128'(0));

        // Asynchronous reset two cycles into BUSY.
        in_valid[0] = 1'b1;
        in_state[0] = rand128();
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 128'(busy[0]), 128'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid[0]), 128'(0));
        check("mid_rst_busy", 128'(busy[0]), 128'(0));
        check("mid_rst_in_ready", 128'(in_ready[0]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_in_ready", 128'(in_ready[0]), 128'(1));
        out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("mid_no_stale%0d", i), 128'(out_valid[0]), 128'(0));
            @(posedge clk); #1;
        end
        check("mid_state_cleared", out_state[0], 128'(0));
        out_ready[0] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_iter.md
Name: inv_mix_columns_iter

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the forward column-mixing stage.
- Takes one 128-bit state and processes COLS_PER_CYCLE columns per clock through shared GF(2^8) multiply logic.
- Returns the result through a valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes/AddRoundKey in the iterative decryption round loop, trading latency for area.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2, 4; anything else is an elaboration error. Latency is N = 4/COLS_PER_CYCLE cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  engine can accept in_state this cycle
- in_state  input  128  state to transform
- out_valid  output  1  out_state holds a completed result
- out_ready  input  1  consumer accepts out_state this cycle
- out_state  output  128  InvMixColumns(in_state)
- busy  output  1  high in BUSY or DONE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All state resets immediately on rst_n low, independent of clk.
- Byte layout: column c occupies in_state[c*32+:32]. Row 0 is the most significant byte of the column ([c*32+24+:8]), row 3 the least.
- Per-column arithmetic, rows r0..r3 in, o0..o3 out, GF(2^8) with polynomial 0x11b:
  - o0 = 0e*r0 ^ 0b*r1 ^ 0d*r2 ^ 09*r3
  - o1 = 09*r0 ^ 0e*r1 ^ 0b*r2 ^ 0d*r3
  - o2 = 0d*r0 ^ 09*r1 ^ 0e*r2 ^ 0b*r3
  - o3 = 0b*r0 ^ 0d*r1 ^ 09*r2 ^ 0e*r3
- Multiplication: xtime chains (x2, x4, x8) with conditional 0x1b reduction. No lookup tables.
- Processing order: column 3 (bits [127:96]) first, then descending. Each cycle processes COLS_PER_CYCLE columns.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. A handshake (in_valid&&in_ready) loads in_state into the working register, clears the column counter to 0, and moves to BUSY.
  - BUSY: each cycle, the selected columns in the working register are overwritten in place with their transformed value, and the counter advances by COLS_PER_CYCLE. When the last group is written, move to DONE.
  - DONE: out_valid=1 and out_state = working register, held stable until out_ready.
    - If out_ready and in_valid are both high: the new state is accepted in the same cycle (in_ready = out_ready in DONE) and the FSM moves to BUSY, giving back-to-back operation with no IDLE bubble.
    - If out_ready is high and in_valid is low: move to IDLE.
- Latency: handshake at edge T gives out_valid high after edge T+N. Throughput is one block per N+1 cycles.
- in_ready is 0 throughout BUSY. in_state is ignored whenever no handshake occurs.
- out_state is don't-care-but-stable while out_valid=0: it shows the working register and does not toggle without cause.
- Reset values: FSM=IDLE, counter=0, working register=0, out_valid=0, in_ready=1 after reset release (0 during reset), busy=0, out_state=0.
- Reset mid-operation: any in-flight block is discarded and no out_valid is produced for it.
- out_valid is never deasserted without out_ready; out_state is constant while out_valid&&!out_ready.

Test Plan:
- FIPS-197 column vectors, COLS_PER_CYCLE=1. Input columns 3..0 = 8e4da1bc, 9f dc 58 9d, 4d7ebdf8, 01010101 -> out columns db135345, f20a225c, 2d26314c, 01010101. out_valid exactly 4 cycles after the accept edge.
- Fixed points and round-trip. in_state = c6c6c6c6_d5d5d7d6_01010101_c6c6c6c6 -> c6c6c6c6_d4d4d4d5_01010101_c6c6c6c6. Then 1000 random states passed through the forward column mix and this block must return the original. Repeat for COLS_PER_CYCLE=1, 2, 4, with latency 4, 2, 1.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> out_state and out_valid stable, in_ready=0, an in_valid pulse is ignored. Raise out_ready -> single transfer, then IDLE.
- Back-to-back: in_valid held high with 3 queued states and out_ready=1 -> each accepted on its DONE cycle, outputs every 5 cycles (N=4), no IDLE cycle between blocks.
- Reset mid-op: assert rst_n=0 asynchronously two cycles into BUSY -> out_valid=0 and busy=0 immediately, without a clock edge. After release in_ready=1 and no stale output appears.
- All-zero and all-ff inputs -> 0 maps to 0; ff-filled columns map to ffffffff (row sum of coefficients is 1).
